// File: rtl/jmp_defs.sv
// Purpose: jump opcodes and flag bit positions shared by the flag register and the jump-condition unit.
// Latency: none, declarations only.
// Backpressure: none.
package jmp_defs;

  localparam logic [3:0] ZERO          = 4'd0;
  localparam logic [3:0] NOTZERO       = 4'd1;
  localparam logic [3:0] EQUAL         = 4'd2;
  localparam logic [3:0] NOTEQUAL      = 4'd3;
  localparam logic [3:0] GREATER       = 4'd4;
  localparam logic [3:0] LESS          = 4'd5;
  localparam logic [3:0] GREATEQUAL    = 4'd6;
  localparam logic [3:0] LESSEQUAL     = 4'd7;
  localparam logic [3:0] CARRY         = 4'd8;
  localparam logic [3:0] NOTCARRY      = 4'd9;
  localparam logic [3:0] UNCONDITIONAL = 4'd10;

  localparam int FLAG_C = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_W = 3;

  typedef logic [FLAG_W-1:0] flags_t;

  // Flags consumed (cleared) by a taken jump of the given opcode.
  function automatic flags_t jmp_clear_mask(input logic [3:0] op);
    flags_t m;
    m = '0;
    case (op)
      ZERO, EQUAL: m[FLAG_Z] = 1'b1;
      CARRY:       m[FLAG_C] = 1'b1;
      LESS:        m[FLAG_S] = 1'b1;
      default:     m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// Purpose: small LIFO of 3-bit flag snapshots for nested interrupt save/restore, with sticky error.
// Latency: push/pop take effect on the next clock; dout shows the current top combinationally.
// Backpressure: none; push when full or pop when empty is dropped and sets err, push+pop together is dropped and sets err.
module flag_stack #(
  parameter int DEPTH = 4,  // at least 1
  parameter int PTR_W = 3   // 2**PTR_W must exceed DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty,
  output logic       err
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic             do_push;
  logic [2:0]       mem_q [DEPTH];

  assign full  = (ptr_q == PTR_W'(DEPTH));
  assign empty = (ptr_q == '0);
  assign err   = err_q;

  // Pointer/error next state; a simultaneous push and pop is refused outright.
  always_comb begin
    ptr_d   = ptr_q;
    err_d   = err_q;
    do_push = 1'b0;
    if (push && pop) begin
      err_d = 1'b1;
    end else if (push) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        do_push = 1'b1;
        ptr_d   = ptr_q + 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        ptr_d = ptr_q - 1'b1;
      end
    end
  end

  // Top-of-stack read: entry ptr-1, zero when nothing is held.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_q == PTR_W'(i + 1)) dout = mem_q[i];
    end
  end

  // Pointer and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  // Snapshot storage; entries above the pointer are never read, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (ptr_q == PTR_W'(i))) mem_q[i] <= din;
    end
  end

endmodule

// File: rtl/flag_reg_unit.sv
// Purpose: condition-code register (C/S/Z) with ALU capture, SETC/CLRC, jump consume-clear and interrupt save/restore.
// Latency: every request is visible on carry/sign/zero one clock later; outputs are purely registered.
// Backpressure: none; illegal stack operations are dropped and flagged on sticky stack_err.
module flag_reg_unit
  import jmp_defs::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_valid,
  input  logic       alu_carry,
  input  logic       alu_sign,
  input  logic       alu_zero,
  input  logic [2:0] alu_fmask,
  input  logic       setc,
  input  logic       clrc,
  input  logic       jmp_taken,
  input  logic [3:0] jmp_op,
  input  logic       int_save,
  input  logic       int_restore,
  output logic       carry,
  output logic       sign,
  output logic       zero,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       stack_err
);

  flags_t flags_q, flags_d;
  flags_t alu_vec, clr_mask, pop_dat;
  logic   restore_ok;

  // Snapshots hold the pre-update flags; the stack itself decides full/empty/conflict handling.
  flag_stack #(
    .DEPTH (STACK_DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (int_save),
    .pop   (int_restore),
    .din   (flags_q),
    .dout  (pop_dat),
    .full  (stack_full),
    .empty (stack_empty),
    .err   (stack_err)
  );

  // Flag next state, applied lowest priority first so later sources override earlier ones.
  always_comb begin
    alu_vec         = '0;
    alu_vec[FLAG_C] = alu_carry;
    alu_vec[FLAG_S] = alu_sign;
    alu_vec[FLAG_Z] = alu_zero;
    clr_mask        = jmp_taken ? jmp_clear_mask(jmp_op) : '0;
    // A restore paired with a save is refused by the stack, so it must not load flags either.
    restore_ok      = int_restore && !int_save && !stack_empty;

    flags_d = flags_q;
    for (int i = 0; i < FLAG_W; i++) begin
      if (alu_valid && alu_fmask[i]) flags_d[i] = alu_vec[i];
    end
    if (setc) flags_d[FLAG_C] = 1'b1;
    if (clrc) flags_d[FLAG_C] = 1'b0;
    flags_d = flags_d & ~clr_mask;
    if (restore_ok) flags_d = pop_dat;
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign carry = flags_q[FLAG_C];
  assign sign  = flags_q[FLAG_S];
  assign zero  = flags_q[FLAG_Z];

endmodule

// File: tb/tb_flag_reg_unit.sv
// Purpose: self-checking bench for flag_reg_unit; directed scenarios then random traffic against a reference model.
// Latency: checks each cycle's outputs 1 time unit after the clock edge that applied the inputs.
// Backpressure: none.
module tb_flag_reg_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid, alu_carry, alu_sign, alu_zero;
  logic [2:0] alu_fmask;
  logic       setc, clrc, jmp_taken;
  logic [3:0] jmp_op;
  logic       int_save, int_restore;
  logic       carry, sign, zero, stack_empty, stack_full, stack_err;

  int total = 0;
  int bad   = 0;

  // Reference state: flags, snapshot list (back = most recent), sticky error.
  bit       m_c, m_s, m_z, m_err;
  bit [2:0] m_stk[$];

  always #5 clk = ~clk;

  flag_reg_unit #(.STACK_DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_carry   (alu_carry),
    .alu_sign    (alu_sign),
    .alu_zero    (alu_zero),
    .alu_fmask   (alu_fmask),
    .setc        (setc),
    .clrc        (clrc),
    .jmp_taken   (jmp_taken),
    .jmp_op      (jmp_op),
    .int_save    (int_save),
    .int_restore (int_restore),
    .carry       (carry),
    .sign        (sign),
    .zero        (zero),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; alu_valid = 1'b0; alu_carry = 1'b0; alu_sign = 1'b0; alu_zero = 1'b0;
    alu_fmask = 3'b000; setc = 1'b0; clrc = 1'b0; jmp_taken = 1'b0; jmp_op = 4'd0;
    int_save = 1'b0; int_restore = 1'b0;
  endtask

  task automatic set_alu(input bit c, input bit s, input bit z, input bit [2:0] m);
    alu_valid = 1'b1; alu_carry = c; alu_sign = s; alu_zero = z; alu_fmask = m;
  endtask

  // Reference behaviour for one clock, from the documented priority rules.
  task automatic model_step();
    bit [2:0] old;
    bit [2:0] snap;
    bit       popped;
    old    = {m_c, m_s, m_z};
    popped = 1'b0;
    snap   = 3'b000;
    if (rst) begin
      m_c = 0; m_s = 0; m_z = 0; m_err = 0;
      m_stk.delete();
    end else begin
      if (int_save && int_restore) m_err = 1;
      else if (int_save) begin
        if (m_stk.size() == DEPTH) m_err = 1;
        else m_stk.push_back(old);
      end else if (int_restore) begin
        if (m_stk.size() == 0) m_err = 1;
        else begin
          snap   = m_stk.pop_back();
          popped = 1'b1;
        end
      end
      if (popped) begin
        {m_c, m_s, m_z} = snap;
      end else begin
        if (jmp_taken && jmp_op == 4'd8)     m_c = 0;
        else if (clrc)                       m_c = 0;
        else if (setc)                       m_c = 1;
        else if (alu_valid && alu_fmask[0])  m_c = alu_carry;
        if (jmp_taken && jmp_op == 4'd5)     m_s = 0;
        else if (alu_valid && alu_fmask[1])  m_s = alu_sign;
        if (jmp_taken && (jmp_op == 4'd0 || jmp_op == 4'd2)) m_z = 0;
        else if (alu_valid && alu_fmask[2])  m_z = alu_zero;
      end
    end
  endtask

  task automatic check_all(input string where);
    expect_eq({where, ".carry"}, carry, m_c);
    expect_eq({where, ".sign"}, sign, m_s);
    expect_eq({where, ".zero"}, zero, m_z);
    expect_eq({where, ".empty"}, stack_empty, (m_stk.size() == 0));
    expect_eq({where, ".full"}, stack_full, (m_stk.size() == DEPTH));
    expect_eq({where, ".err"}, stack_err, m_err);
  endtask

  // One clock: DUT and model consume the same inputs, then outputs are compared, then inputs go idle.
  task automatic tick(input string where);
    @(posedge clk);
    model_step();
    #1;
    check_all(where);
    idle();
  endtask

  initial begin
    bit [2:0] exp_pop [4];
    idle();
    rst = 1'b1;
    m_c = 0; m_s = 0; m_z = 0; m_err = 0;
    tick("reset");
    expect_eq("rst_flags", {carry, sign, zero}, 3'b000);
    expect_eq("rst_empty", stack_empty, 1'b1);
    expect_eq("rst_full", stack_full, 1'b0);
    expect_eq("rst_err", stack_err, 1'b0);

    // ALU capture, full mask then sign only.
    set_alu(1, 0, 1, 3'b111); tick("alu_all");
    expect_eq("alu_all_csz", {carry, sign, zero}, 3'b101);
    set_alu(0, 1, 0, 3'b010); tick("alu_s");
    expect_eq("alu_s_csz", {carry, sign, zero}, 3'b111);

    // SETC/CLRC; clrc wins a tie.
    setc = 1; clrc = 1; tick("setclr");
    expect_eq("setclr_c", carry, 1'b0);
    setc = 1; tick("setc");
    expect_eq("setc_c", carry, 1'b1);
    clrc = 1; tick("clrc");
    expect_eq("clrc_c", carry, 1'b0);

    // Jump consume-clear.
    set_alu(1, 0, 1, 3'b111); tick("jprep");
    jmp_taken = 1; jmp_op = 4'd0; tick("jzero");
    expect_eq("jzero_cz", {carry, zero}, 2'b10);
    jmp_taken = 1; jmp_op = 4'd8; tick("jcarry");
    expect_eq("jcarry_c", carry, 1'b0);
    set_alu(1, 1, 1, 3'b111); tick("jprep2");
    jmp_taken = 1; jmp_op = 4'd10; tick("juncond");
    expect_eq("juncond_csz", {carry, sign, zero}, 3'b111);
    jmp_taken = 1; jmp_op = 4'd2; setc = 1; clrc = 0; tick("jeq_setc");

    // Save, overwrite, restore.
    set_alu(1, 1, 0, 3'b111); tick("sv_prep");
    int_save = 1; tick("save");
    set_alu(0, 0, 1, 3'b111); tick("overwrite");
    int_restore = 1; tick("restore");
    expect_eq("restore_csz", {carry, sign, zero}, 3'b110);
    expect_eq("restore_empty", stack_empty, 1'b1);

    // Fill the stack, overflow, drain in reverse, underflow.
    for (int i = 0; i < DEPTH; i++) begin
      int_save = 1;
      set_alu(((i + 1) >> 2) & 1, ((i + 1) >> 1) & 1, (i + 1) & 1, 3'b111);
      tick("push");
    end
    expect_eq("fill_full", stack_full, 1'b1);
    int_save = 1; tick("overflow");
    expect_eq("ovf_err", stack_err, 1'b1);
    expect_eq("ovf_full", stack_full, 1'b1);
    exp_pop[0] = 3'b011; exp_pop[1] = 3'b010; exp_pop[2] = 3'b001; exp_pop[3] = 3'b110;
    for (int i = 0; i < DEPTH; i++) begin
      int_restore = 1; tick("pop");
      expect_eq("pop_order", {carry, sign, zero}, exp_pop[i]);
    end
    int_restore = 1; tick("underflow");
    expect_eq("unf_csz", {carry, sign, zero}, 3'b110);
    expect_eq("unf_err", stack_err, 1'b1);

    // Simultaneous save and restore, then reset.
    rst = 1; tick("rst2");
    int_save = 1; int_restore = 1; set_alu(1, 0, 0, 3'b001); tick("saverest");
    expect_eq("sr_c", carry, 1'b1);
    expect_eq("sr_err", stack_err, 1'b1);
    expect_eq("sr_empty", stack_empty, 1'b1);
    rst = 1; tick("rst3");
    expect_eq("rst3_state", {carry, sign, zero, stack_err, stack_empty}, 5'b00001);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      alu_valid   = $urandom_range(0, 1);
      alu_carry   = $urandom_range(0, 1);
      alu_sign    = $urandom_range(0, 1);
      alu_zero    = $urandom_range(0, 1);
      alu_fmask   = 3'($urandom_range(0, 7));
      setc        = ($urandom_range(0, 5) == 0);
      clrc        = ($urandom_range(0, 5) == 0);
      jmp_taken   = ($urandom_range(0, 2) == 0);
      jmp_op      = 4'($urandom_range(0, 15));
      int_save    = ($urandom_range(0, 4) == 0);
      int_restore = ($urandom_range(0, 4) == 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
